// File: rtl/axi_xbar_pkg.sv
// Shared crossbar types and helpers; holds the FIFO status bundle so callers can
// pass occupancy and level flags around as one value.
package axi_xbar_pkg;

   localparam int unsigned FifoCntW = 16;

   typedef struct packed {
      logic [FifoCntW-1:0] count;
      logic                awfull;
      logic                arempty;
   } fifo_status_t;

   function automatic logic lvl_at_least(input int unsigned cnt, input int unsigned lvl);
      return cnt >= lvl;
   endfunction

   function automatic logic lvl_at_most(input int unsigned cnt, input int unsigned lvl);
      return cnt <= lvl;
   endfunction

endpackage

// File: rtl/fifomem.sv
// Dual-port FIFO storage: synchronous write, and either combinational (fall-through)
// or registered read data.
module fifomem #(
   parameter int unsigned DATASIZE    = 8,
   parameter int unsigned ADDRSIZE    = 4,
   parameter int unsigned DEPTH       = 2**ADDRSIZE,
   parameter string       FALLTHROUGH = "TRUE"
) (
   input  logic                wclk,
   input  logic                wclken,
   input  logic [ADDRSIZE-1:0] waddr,
   input  logic [DATASIZE-1:0] wdata,
   input  logic                rclk,
   input  logic                rrst,
   input  logic                rclken,
   input  logic [ADDRSIZE-1:0] raddr,
   output logic [DATASIZE-1:0] rdata
);

   logic [DATASIZE-1:0] mem [DEPTH];

   always_ff @(posedge wclk) begin
      if (wclken) mem[waddr] <= wdata;
   end

   if (FALLTHROUGH == "TRUE") begin : g_fwft
      logic unused_rd;
      assign unused_rd = ^{rclk, rrst, rclken};
      assign rdata     = mem[raddr];
   end else begin : g_reg
      logic [DATASIZE-1:0] rdata_d, rdata_q;

      // Holds the last popped word until the next accepted pop.
      always_comb begin
         rdata_d = rdata_q;
         if (rclken) rdata_d = mem[raddr];
      end

      always_ff @(posedge rclk) begin
         if (rrst) rdata_q <= '0;
         else      rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
   end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with binary pointers, occupancy count, programmable level flags,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_lvl
   import axi_xbar_pkg::*;
#(
   parameter int unsigned DSIZE       = 8,
   parameter int unsigned ASIZE       = 4,
   parameter string       FALLTHROUGH = "TRUE",
   parameter int unsigned AFULL_LVL   = 2**ASIZE-1,
   parameter int unsigned AEMPTY_LVL  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   output logic             awfull,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             arempty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int unsigned DEPTH = 2**ASIZE;

   logic [ASIZE:0] wptr_d, wptr_q, rptr_d, rptr_q, count_d, count_q;
   logic           rempty_d, rempty_q, wfull_d, wfull_q;
   logic           overflow_d, overflow_q, underflow_d, underflow_q;
   logic           push, pop;

   always_comb begin
      // Flush drops any request in the same cycle and must not raise an error flag.
      push        = winc & ~wfull_q & ~flush;
      pop         = rinc & ~rempty_q & ~flush;
      overflow_d  = overflow_q | (winc & wfull_q & ~flush);
      underflow_d = underflow_q | (rinc & rempty_q & ~flush);
      wptr_d      = wptr_q + (ASIZE+1)'(push);
      rptr_d      = rptr_q + (ASIZE+1)'(pop);
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end
      count_d  = wptr_d - rptr_d;
      rempty_d = (wptr_d == rptr_d);
      wfull_d  = (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]) && (wptr_d[ASIZE] != rptr_d[ASIZE]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rempty_q    <= 1'b1;
         wfull_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         rempty_q    <= rempty_d;
         wfull_q     <= wfull_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifomem #(
      .DATASIZE    (DSIZE),
      .ADDRSIZE    (ASIZE),
      .DEPTH       (DEPTH),
      .FALLTHROUGH (FALLTHROUGH)
   ) u_fifomem (
      .wclk   (clk),
      .wclken (push),
      .waddr  (wptr_q[ASIZE-1:0]),
      .wdata  (wdata),
      .rclk   (clk),
      .rrst   (rst),
      .rclken (pop),
      .raddr  (rptr_q[ASIZE-1:0]),
      .rdata  (rdata)
   );

   assign count     = count_q;
   assign rempty    = rempty_q;
   assign wfull     = wfull_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign awfull    = lvl_at_least(32'(count_q), AFULL_LVL);
   assign arempty   = lvl_at_most(32'(count_q), AEMPTY_LVL);

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Drives a fall-through and a registered-read FIFO with identical stimulus and checks
// both against a queue-based reference.
module tb_sync_fifo_lvl;

   localparam int unsigned DSIZE = 8;
   localparam int unsigned ASIZE = 2;
   localparam int unsigned DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             winc = 1'b0;
   logic             rinc = 1'b0;
   logic [DSIZE-1:0] wdata = '0;

   logic             ft_wfull, ft_awfull, ft_rempty, ft_arempty, ft_ovf, ft_udf;
   logic [DSIZE-1:0] ft_rdata;
   logic [ASIZE:0]   ft_count;
   logic             rg_wfull, rg_awfull, rg_rempty, rg_arempty, rg_ovf, rg_udf;
   logic [DSIZE-1:0] rg_rdata;
   logic [ASIZE:0]   rg_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DSIZE-1:0] m_q [$];
   logic             m_ovf = 1'b0;
   logic             m_udf = 1'b0;
   logic [DSIZE-1:0] m_rd  = '0;

   always #5 clk = ~clk;

   sync_fifo_lvl #(
      .DSIZE (DSIZE), .ASIZE (ASIZE), .FALLTHROUGH ("TRUE"), .AFULL_LVL (3), .AEMPTY_LVL (1)
   ) u_dut_ft (
      .clk (clk), .rst (rst), .flush (flush), .winc (winc), .wdata (wdata),
      .wfull (ft_wfull), .awfull (ft_awfull), .rinc (rinc), .rdata (ft_rdata),
      .rempty (ft_rempty), .arempty (ft_arempty), .count (ft_count),
      .overflow (ft_ovf), .underflow (ft_udf)
   );

   sync_fifo_lvl #(
      .DSIZE (DSIZE), .ASIZE (ASIZE), .FALLTHROUGH ("FALSE"), .AFULL_LVL (3), .AEMPTY_LVL (1)
   ) u_dut_rg (
      .clk (clk), .rst (rst), .flush (flush), .winc (winc), .wdata (wdata),
      .wfull (rg_wfull), .awfull (rg_awfull), .rinc (rinc), .rdata (rg_rdata),
      .rempty (rg_rempty), .arempty (rg_arempty), .count (rg_count),
      .overflow (rg_ovf), .underflow (rg_udf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      int sz;
      sz = m_q.size();
      check_eq("ft.count",   32'(ft_count), sz);
      check_eq("ft.rempty",  32'(ft_rempty), 32'(sz == 0));
      check_eq("ft.wfull",   32'(ft_wfull), 32'(sz == DEPTH));
      check_eq("ft.awfull",  32'(ft_awfull), 32'(sz >= 3));
      check_eq("ft.arempty", 32'(ft_arempty), 32'(sz <= 1));
      check_eq("ft.ovf",     32'(ft_ovf), 32'(m_ovf));
      check_eq("ft.udf",     32'(ft_udf), 32'(m_udf));
      if (sz > 0) check_eq("ft.rdata", 32'(ft_rdata), 32'(m_q[0]));
      check_eq("rg.count",   32'(rg_count), sz);
      check_eq("rg.rempty",  32'(rg_rempty), 32'(sz == 0));
      check_eq("rg.wfull",   32'(rg_wfull), 32'(sz == DEPTH));
      check_eq("rg.awfull",  32'(rg_awfull), 32'(sz >= 3));
      check_eq("rg.arempty", 32'(rg_arempty), 32'(sz <= 1));
      check_eq("rg.ovf",     32'(rg_ovf), 32'(m_ovf));
      check_eq("rg.udf",     32'(rg_udf), 32'(m_udf));
      check_eq("rg.rdata",   32'(rg_rdata), 32'(m_rd));
   endtask

   // One clock: apply inputs, advance the reference on the edge, then compare.
   task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r,
                       input logic f, input logic rs);
      logic full, empty;
      winc  = w;
      wdata = d;
      rinc  = r;
      flush = f;
      rst   = rs;
      @(posedge clk);
      full  = (m_q.size() == DEPTH);
      empty = (m_q.size() == 0);
      if (rs) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_rd  = '0;
      end else if (f) begin
         m_q.delete();
      end else begin
         if (w && full)  m_ovf = 1'b1;
         if (r && empty) m_udf = 1'b1;
         if (r && !empty) m_rd = m_q.pop_front();
         if (w && !full)  m_q.push_back(d);
      end
      #1;
      check_all();
   endtask

   initial begin
      step(0, 8'h00, 0, 0, 1);
      // Fill, then push while full, then drain.
      step(1, 8'h11, 0, 0, 0);
      step(1, 8'h22, 0, 0, 0);
      step(1, 8'h33, 0, 0, 0);
      step(1, 8'h44, 0, 0, 0);
      step(1, 8'h55, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
      // Pops on empty.
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      // Simultaneous push/pop at count 2 across the pointer wrap.
      step(1, 8'h01, 0, 0, 0);
      step(1, 8'h02, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 8'hA0 + 8'(i), 1, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      // Flush at count 3 with a concurrent push.
      step(1, 8'h61, 0, 0, 0);
      step(1, 8'h62, 0, 0, 0);
      step(1, 8'h63, 0, 0, 0);
      step(1, 8'h64, 0, 1, 0);
      step(1, 8'h77, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      // Reset mid-stream at count 2.
      step(1, 8'h81, 0, 0, 0);
      step(1, 8'h82, 0, 0, 0);
      step(0, 8'h00, 0, 0, 1);
      step(0, 8'h00, 0, 0, 0);
      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         step(logic'($urandom_range(0, 99) < 55), 8'($urandom), logic'($urandom_range(0, 99) < 50),
              logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 149) == 0));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
